// File: rtl/rr_req_mux_4_pkg.sv
// Shared constants, FSM encoding and one-hot helper for the 4-channel
// request front end and its round-robin arbiter.
package rr_req_mux_4_pkg;

  localparam int NUM_CH   = 4;
  localparam int CH_IDX_W = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Ones are ORed together, so a non-one-hot input yields a meaningless index;
  // callers qualify the vector first.
  function automatic logic [CH_IDX_W-1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
    logic [CH_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (oh[i]) idx = idx | CH_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_req_mux_4_if.sv
// Bundle of the requester, arbiter and downstream signals of rr_req_mux_4.
// Handshake: a word moves on any cycle where valid & ready are both 1 at the
// rising edge; valid, once raised, holds with stable data until ready is seen.
interface rr_req_mux_4_if
  import rr_req_mux_4_pkg::*;
#(
  parameter int DATA_W = 32
) ();

  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH-1:0]        grant;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [CH_IDX_W-1:0]      out_src;
  logic                     out_ready;
  logic                     grant_err;
  state_e                   dbg_state;

  modport slave (
    input  in_valid, in_data, grant, out_ready,
    output in_ready, req, out_valid, out_data, out_src, grant_err, dbg_state
  );

  modport master (
    output in_valid, in_data, grant, out_ready,
    input  in_ready, req, out_valid, out_data, out_src, grant_err, dbg_state
  );

endinterface

// File: rtl/rr_req_mux_4_slot.sv
// One-entry holding register with pending flag for a single requester channel.
module req_hold_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              clear_i,
  output logic              pending_o,
  output logic [DATA_W-1:0] data_o
);

  logic              pending_q, pending_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              capture;

  // Ready is the registered empty flag, so a slot cleared this cycle refills next cycle.
  assign capture = in_valid_i & ~pending_q;

  always_comb begin
    pending_d = pending_q;
    data_d    = data_q;
    if (capture) begin
      pending_d = 1'b1;
      data_d    = in_data_i;
    end else if (clear_i) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      data_q    <= '0;
    end else begin
      pending_q <= pending_d;
      data_q    <= data_d;
    end
  end

  assign pending_o = pending_q;
  assign data_o    = data_q;

endmodule

// File: rtl/rr_req_mux_4.sv
// Four-requester front end: holds one word per channel, requests the arbiter,
// and forwards the granted channel's word over a single valid/ready port.
module rr_req_mux_4
  import rr_req_mux_4_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_req_mux_4_if.slave  bus
);

  state_e                state_q, state_d;
  logic [CH_IDX_W-1:0]   owner_q, owner_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic                  grant_err_q, grant_err_d;

  logic [NUM_CH-1:0]     pending;
  logic [NUM_CH-1:0]     clear;
  logic [NUM_CH-1:0]     send_mask;
  logic [DATA_W-1:0]     hold_data [NUM_CH];
  logic                  grant_multi;
  logic                  grant_hit;
  logic [CH_IDX_W-1:0]   grant_idx;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    req_hold_slot #(.DATA_W(DATA_W)) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (bus.in_valid[g]),
      .in_data_i  (bus.in_data[g*DATA_W +: DATA_W]),
      .clear_i    (clear[g]),
      .pending_o  (pending[g]),
      .data_o     (hold_data[g])
    );
  end

  // x & (x-1) is non-zero exactly when more than one bit is set.
  assign grant_multi = |(bus.grant & (bus.grant - {{(NUM_CH-1){1'b0}}, 1'b1}));
  assign grant_hit   = |(bus.grant & pending);
  assign grant_idx   = onehot_to_idx(bus.grant);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      grant_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      grant_err_q <= grant_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    grant_err_d = grant_err_q;
    case (state_q)
      ST_IDLE: begin
        // A lone grant to an empty slot is the arbiter's lag after req fell: ignore it.
        if (grant_multi) begin
          grant_err_d = 1'b1;
        end else if (grant_hit) begin
          state_d     = ST_SEND;
          owner_d     = grant_idx;
          out_data_d  = hold_data[grant_idx];
          out_valid_d = 1'b1;
        end
      end
      ST_SEND: begin
        if (bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    send_mask = '0;
    clear     = '0;
    if (state_q == ST_SEND) begin
      send_mask[owner_q] = 1'b1;
      clear[owner_q]     = bus.out_ready;
    end
  end

  // Masking the owner keeps the arbiter from granting it again mid-transfer.
  assign bus.req       = pending & ~send_mask;
  assign bus.in_ready  = ~pending;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = owner_q;
  assign bus.grant_err = grant_err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_rr_req_mux_4.sv
// Scenario bench for rr_req_mux_4: directed tasks plus an output scoreboard
// and a small locking round-robin arbiter model for the multi-channel case.
module tb_rr_req_mux_4;
  import rr_req_mux_4_pkg::*;

  localparam int DW = 32;
  localparam int W  = DW + CH_IDX_W;

  logic clk;
  logic rst_n;
  logic arb_en;
  logic [3:0] tb_grant;
  logic [3:0] arb_grant;
  logic [1:0] arb_ptr;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  int n_vec;
  int n_err;

  rr_req_mux_4_if #(.DATA_W(DW)) bus_if ();

  rr_req_mux_4 #(.DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  assign bus_if.grant = arb_en ? arb_grant : tb_grant;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- arbiter model ----------------
  function automatic logic [3:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] j;
    for (int k = 0; k < 4; k++) begin
      j = p + 2'(k);
      if (r[j]) return 4'b0001 << j;
    end
    return 4'b0000;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      arb_grant <= 4'b0000;
      arb_ptr   <= 2'd0;
    end else if (|(arb_grant & bus_if.req)) begin
      arb_grant <= arb_grant;
    end else begin
      arb_grant <= rr_pick(bus_if.req, arb_ptr);
      if (|bus_if.req) arb_ptr <= onehot_to_idx(rr_pick(bus_if.req, arb_ptr)) + 2'd1;
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL out_unexpected: got src=%0d data=%h, required no output", bus_if.out_src, bus_if.out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus_if.out_src, bus_if.out_data} !== mon_exp) begin
          n_err++;
          $display("FAIL out_word: got src=%0d data=%h, required src=%0d data=%h",
                   bus_if.out_src, bus_if.out_data, mon_exp[W-1 -: CH_IDX_W], mon_exp[DW-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load(input logic [3:0] mask, input logic [4*DW-1:0] data);
    bus_if.in_valid = mask;
    bus_if.in_data  = data;
    tick();
    bus_if.in_valid = 4'b0000;
  endtask

  task automatic drain_one(input int ch, input logic [DW-1:0] data);
    tb_grant = 4'b0001 << ch;
    tick();
    tb_grant = 4'b0000;
    n_vec++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out_src !== 2'(ch) || bus_if.out_data !== data) begin
      n_err++;
      $display("FAIL drain_start ch%0d: got v=%b src=%0d data=%h, required v=1 src=%0d data=%h",
               ch, bus_if.out_valid, bus_if.out_src, bus_if.out_data, ch, data);
    end
    exp_q.push_back({2'(ch), data});
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    n_vec++;
    if (bus_if.out_valid !== 1'b0 || bus_if.in_ready[ch] !== 1'b1) begin
      n_err++;
      $display("FAIL drain_end ch%0d: got v=%b in_ready=%b, required v=0 in_ready[ch]=1",
               ch, bus_if.out_valid, bus_if.in_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_vec++;
    if (bus_if.out_valid !== 1'b0 || bus_if.out_data !== '0 || bus_if.out_src !== 2'd0 ||
        bus_if.grant_err !== 1'b0 || bus_if.req !== 4'h0 || bus_if.in_ready !== 4'hF ||
        bus_if.dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_state: got v=%b d=%h src=%0d err=%b req=%b rdy=%b, required 0 0 0 0 0000 1111",
               bus_if.out_valid, bus_if.out_data, bus_if.out_src, bus_if.grant_err, bus_if.req, bus_if.in_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    load(4'b0100, {32'h0, 32'hA5A5_0002, 64'h0});
    n_vec++;
    if (bus_if.req !== 4'b0100 || bus_if.in_ready !== 4'b1011 || bus_if.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_n1: got req=%b rdy=%b v=%b, required req=0100 rdy=1011 v=0",
               bus_if.req, bus_if.in_ready, bus_if.out_valid);
    end
    tick();
    tb_grant = 4'b0100;
    n_vec++;
    if (bus_if.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_n2: got v=%b, required v=0", bus_if.out_valid);
    end
    tick();
    tb_grant = 4'b0000;
    n_vec++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out_src !== 2'd2 || bus_if.out_data !== 32'hA5A5_0002 ||
        bus_if.req !== 4'b0000) begin
      n_err++;
      $display("FAIL single_n3: got v=%b src=%0d d=%h req=%b, required v=1 src=2 d=a5a50002 req=0000",
               bus_if.out_valid, bus_if.out_src, bus_if.out_data, bus_if.req);
    end
    exp_q.push_back({2'd2, 32'hA5A5_0002});
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    n_vec++;
    if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 4'hF || bus_if.dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL single_done: got v=%b rdy=%b, required v=0 rdy=1111", bus_if.out_valid, bus_if.in_ready);
    end
  endtask

  task automatic test_all_four();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    arb_en = 1'b1;
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), 32'h10 + 32'(i)});
    load(4'b1111, {32'h13, 32'h12, 32'h11, 32'h10});
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) tick();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL all_four_timeout: got %0d words outstanding, required 0", exp_q.size());
    end
    for (int c = 0; c < 4; c++) tick();
    n_vec++;
    if (bus_if.in_ready !== 4'hF || bus_if.req !== 4'h0 || bus_if.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL all_four_idle: got rdy=%b req=%b v=%b, required 1111 0000 0",
               bus_if.in_ready, bus_if.req, bus_if.out_valid);
    end
    bus_if.out_ready = 1'b0;
    arb_en = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_backpressure_and_stale();
    logic [DW-1:0] d0, d1, d3;
    logic [3:0] gseq [5];
    gseq = '{4'b0010, 4'b1000, 4'b0011, 4'b0010, 4'b1000};
    d0 = $urandom;
    d1 = $urandom;
    d3 = $urandom;
    load(4'b1011, {d3, 32'h0, d1, d0});
    tb_grant = 4'b0001;
    tick();
    for (int i = 0; i < 5; i++) begin
      tb_grant = gseq[i];
      tick();
      n_vec++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_src !== 2'd0 || bus_if.out_data !== d0 ||
          bus_if.req !== 4'b1010 || bus_if.grant_err !== 1'b0 || bus_if.dbg_state !== ST_SEND) begin
        n_err++;
        $display("FAIL backpressure_%0d: got v=%b src=%0d d=%h req=%b err=%b, required v=1 src=0 d=%h req=1010 err=0",
                 i, bus_if.out_valid, bus_if.out_src, bus_if.out_data, bus_if.req, bus_if.grant_err, d0);
      end
    end
    tb_grant = 4'b0000;
    exp_q.push_back({2'd0, d0});
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    n_vec++;
    if (bus_if.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL backpressure_release: got v=%b, required v=0", bus_if.out_valid);
    end
    drain_one(1, d1);
    tb_grant = 4'b0010;
    tick();
    tb_grant = 4'b0000;
    n_vec++;
    if (bus_if.out_valid !== 1'b0 || bus_if.dbg_state !== ST_IDLE || bus_if.req !== 4'b1000 ||
        bus_if.grant_err !== 1'b0) begin
      n_err++;
      $display("FAIL stale_grant: got v=%b st=%0d req=%b err=%b, required v=0 st=0 req=1000 err=0",
               bus_if.out_valid, bus_if.dbg_state, bus_if.req, bus_if.grant_err);
    end
    drain_one(3, d3);
  endtask

  task automatic test_illegal_grant();
    logic [DW-1:0] d0, d1;
    d0 = $urandom;
    d1 = $urandom;
    load(4'b0011, {64'h0, d1, d0});
    tb_grant = 4'b0011;
    tick();
    tb_grant = 4'b0000;
    n_vec++;
    if (bus_if.grant_err !== 1'b1 || bus_if.out_valid !== 1'b0 || bus_if.dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL illegal_grant: got err=%b v=%b st=%0d, required err=1 v=0 st=0",
               bus_if.grant_err, bus_if.out_valid, bus_if.dbg_state);
    end
    tick();
    drain_one(0, d0);
    drain_one(1, d1);
    n_vec++;
    if (bus_if.grant_err !== 1'b1) begin
      n_err++;
      $display("FAIL grant_err_sticky: got err=%b, required err=1", bus_if.grant_err);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_vec++;
    if (bus_if.grant_err !== 1'b0) begin
      n_err++;
      $display("FAIL grant_err_reset: got err=%b, required err=0", bus_if.grant_err);
    end
    tick();
  endtask

  task automatic test_reset_in_send();
    load(4'b0111, {32'h0, 32'hC2, 32'hC1, 32'hC0});
    tb_grant = 4'b0001;
    tick();
    tb_grant = 4'b0000;
    n_vec++;
    if (bus_if.out_valid !== 1'b1 || bus_if.req !== 4'b0110) begin
      n_err++;
      $display("FAIL send_before_reset: got v=%b req=%b, required v=1 req=0110", bus_if.out_valid, bus_if.req);
    end
    rst_n = 1'b0;
    tick();
    n_vec++;
    if (bus_if.out_valid !== 1'b0 || bus_if.req !== 4'h0 || bus_if.in_ready !== 4'hF ||
        bus_if.dbg_state !== ST_IDLE || bus_if.out_src !== 2'd0 || bus_if.out_data !== '0) begin
      n_err++;
      $display("FAIL reset_in_send: got v=%b req=%b rdy=%b st=%0d src=%0d d=%h, required 0 0000 1111 0 0 0",
               bus_if.out_valid, bus_if.req, bus_if.in_ready, bus_if.dbg_state, bus_if.out_src, bus_if.out_data);
    end
    rst_n = 1'b1;
    tick();
    tick();
    n_vec++;
    if (bus_if.out_valid !== 1'b0 || bus_if.req !== 4'h0) begin
      n_err++;
      $display("FAIL after_reset_quiet: got v=%b req=%b, required v=0 req=0000", bus_if.out_valid, bus_if.req);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    arb_en = 1'b0;
    tb_grant = 4'b0000;
    bus_if.in_valid = 4'b0000;
    bus_if.in_data = '0;
    bus_if.out_ready = 1'b0;
    test_reset();
    test_single();
    test_all_four();
    test_backpressure_and_stale();
    test_illegal_grant();
    test_reset_in_send();
    tick();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d words outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rr_req_mux_4.md
Name: rr_req_mux_4

Overview:
- Four-requester front end for the 4-channel round-robin arbiter.
- Each channel has a one-entry holding register. A filled register drives that channel's req line to the arbiter.
- On a one-hot grant from the arbiter, the block locks ownership to the granted channel and forwards its word onto a single shared valid/ready output port.
- It releases the bus only when the downstream side accepts the word.

Parameters:
- DATA_W, 32, width of each request payload word.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  4  per-channel payload valid.
- in_data  input  4*DATA_W  per-channel payload; channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  4  per-channel holding register empty.
- req  output  4  request vector to the arbiter.
- grant  input  4  registered grant vector from the arbiter.
- out_valid  output  1  shared output word valid.
- out_data  output  DATA_W  shared output word.
- out_src  output  2  index of the channel that owns out_data.
- out_ready  input  1  downstream accept.
- grant_err  output  1  sticky flag: a grant with more than one bit set was seen.

Behaviour:
- Reset (rst_n=0 at a clock edge) forces:
  - pending=0, state=IDLE.
  - out_valid=0, out_data=0, out_src=0, grant_err=0.
  - The state above makes req=0 and in_ready=4'hF.
- Reset mid-transfer drops the in-flight word and all pending words without any handshake.
- Per-channel holding register:
  - in_ready[i] = ~pending[i], combinational from the register.
  - When in_valid[i] & in_ready[i]: capture the word and set pending[i] next cycle.
  - No same-cycle refill: a channel whose pending bit clears this cycle shows in_ready=1 only from the next cycle.
- req[i] = pending[i] & ~(state==SEND & owner==i), combinational.
  - The owner's req drops in the same cycle ownership is taken.
  - This stops the arbiter from re-granting the owner.
- FSM, two states:
  - IDLE, grant exactly one-hot at bit g, pending[g]=1: owner<=g, out_data<=hold[g], out_src<=g, out_valid<=1, go to SEND.
  - IDLE, grant zero: stay.
  - IDLE, grant one-hot to a non-pending channel (stale grant, caused by the arbiter's one-cycle register lag after req drops): ignore, stay.
  - IDLE, grant with more than one bit set: ignore, set grant_err, stay.
  - SEND: hold out_valid, out_data and out_src stable, and ignore all grants.
  - SEND, out_ready=1: clear pending[owner], out_valid<=0, return to IDLE. Back-to-back grants therefore cost at least one IDLE cycle.
- Latency from in_valid accepted at cycle N on an idle block:
  - pending and req high at N+1.
  - Arbiter grant at N+2.
  - out_valid at N+3.
- Simultaneous events:
  - Capture on a non-owner channel during SEND is legal and independent of the transfer.
  - Capture on the owner channel is impossible, because its in_ready=0.
- grant_err clears only on reset.
- Fairness comes entirely from the arbiter. This block never reorders beyond latching the one-hot grant.

Decomposition:
- Shared package holds:
  - constants NUM_CH=4 and CH_IDX_W=2.
  - state encodings ST_IDLE and ST_SEND.
  - a onehot_to_idx function, shared with the arbiter's rotate-pointer logic.
- One sub-module, req_hold_slot: a single-channel holding register plus pending bit. Instantiated four times.

Test Plan:
- Single channel: in_valid=4'b0100, data 0xA5A5_0002; arbiter grant 4'b0100 two cycles later. Required: out_valid at N+3 with out_src=2 and out_data=0xA5A5_0002; in_ready[2] returns to 1 the cycle after out_ready.
- All four channels load 0x10..0x13 in the same cycle, arbiter from reset, out_ready tied 1. Required: outputs in order src 0,1,2,3 with data 0x10..0x13; no word duplicated.
- Backpressure: hold out_ready=0 for 5 cycles while grant toggles to other channels. Required: out_valid, out_data and out_src stable; grants ignored; req of non-owners stays 1.
- Stale grant: after channel 1 completes, drive grant=4'b0010 for one IDLE cycle with pending[1]=0. Required: no out_valid and no state change.
- Illegal grant 4'b0011 in IDLE. Required: grant_err=1 next cycle and stays set; no transfer; cleared only by rst_n=0.
- Reset asserted during SEND with 3 channels pending. Required: next cycle out_valid=0, req=0, in_ready=4'hF.
